// File: rtl/pong_pkg.sv
// pong_pkg: shared FSM states, direction encoding and centre constants for the pong ball stage
package pong_pkg;
  typedef enum logic [1:0] {IDLE, SERVE, PLAY, POINT} state_t;
  typedef enum logic {NEG = 1'b0, POS = 1'b1} dir_t;
  localparam int DEF_X_MAX = 63;
  localparam int DEF_Y_MAX = 47;
  function automatic int centre(input int max_v);
    return max_v / 2;
  endfunction
  localparam int CENTRE_X = centre(DEF_X_MAX);
  localparam int CENTRE_Y = centre(DEF_Y_MAX);
endpackage

// File: rtl/pong_paddle_hit.sv
// pong_paddle_hit: combinational paddle range test (i_y, i_paddle_y -> o_hit when i_paddle_y <= i_y < i_paddle_y+PADDLE_H, no wrap)
module pong_paddle_hit
  import pong_pkg::*;
#(
  parameter int Y_W      = 6,
  parameter int PADDLE_H = 8
) (
  input  logic [Y_W-1:0] i_y,
  input  logic [Y_W-1:0] i_paddle_y,
  output logic           o_hit
);
  logic [Y_W:0] w_y;
  logic [Y_W:0] w_top;
  logic [Y_W:0] w_bot;
  assign w_y   = {1'b0, i_y};
  assign w_top = {1'b0, i_paddle_y};
  assign w_bot = w_top + (Y_W+1)'(PADDLE_H);
  assign o_hit = (w_y >= w_top) && (w_y < w_bot);
endmodule

// File: rtl/pong_ball_motion.sv
// pong_ball_motion: ball physics/serve FSM; in clk,reset,tick,start,pause,paddle_l_y,paddle_r_y; out ball_x,ball_y,playing,score_l,score_r (all registered)
module pong_ball_motion
  import pong_pkg::*;
#(
  parameter int X_W         = 6,
  parameter int Y_W         = 6,
  parameter int X_MAX       = DEF_X_MAX,
  parameter int Y_MAX       = DEF_Y_MAX,
  parameter int PADDLE_H    = 8,
  parameter int SERVE_TICKS = 30
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick,
  input  logic           start,
  input  logic           pause,
  input  logic [Y_W-1:0] paddle_l_y,
  input  logic [Y_W-1:0] paddle_r_y,
  output logic [X_W-1:0] ball_x,
  output logic [Y_W-1:0] ball_y,
  output logic           playing,
  output logic           score_l,
  output logic           score_r
);
  localparam int CNT_W = $clog2(SERVE_TICKS + 1);
  localparam logic [X_W-1:0] X_C     = X_W'(centre(X_MAX));
  localparam logic [Y_W-1:0] Y_C     = Y_W'(centre(Y_MAX));
  localparam logic [X_W-1:0] X_ONE   = X_W'(1);
  localparam logic [X_W-1:0] X_TWO   = X_W'(2);
  localparam logic [X_W-1:0] X_LAST  = X_W'(X_MAX);
  localparam logic [X_W-1:0] X_PRE   = X_W'(X_MAX - 1);
  localparam logic [X_W-1:0] X_REB   = X_W'(X_MAX - 2);
  localparam logic [Y_W-1:0] Y_ONE   = Y_W'(1);
  localparam logic [Y_W-1:0] Y_LAST  = Y_W'(Y_MAX);
  localparam logic [Y_W-1:0] Y_PRE   = Y_W'(Y_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(SERVE_TICKS - 1);
  state_t           r_state, w_state;
  logic [X_W-1:0]   r_x, w_x;
  logic [Y_W-1:0]   r_y, w_y;
  dir_t             r_dx, w_dx, r_dy, w_dy;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             r_playing, r_score_l, r_score_r;
  logic             w_score_l, w_score_r;
  logic             w_step, w_hit_l, w_hit_r;
  logic             w_wall_hi, w_wall_lo, w_edge_l, w_edge_r;
  pong_paddle_hit #(.Y_W(Y_W), .PADDLE_H(PADDLE_H)) u_hit_l (
    .i_y(r_y), .i_paddle_y(paddle_l_y), .o_hit(w_hit_l)
  );
  pong_paddle_hit #(.Y_W(Y_W), .PADDLE_H(PADDLE_H)) u_hit_r (
    .i_y(r_y), .i_paddle_y(paddle_r_y), .o_hit(w_hit_r)
  );
  assign w_step    = tick & ~pause;
  assign w_wall_hi = (r_dy == POS) && (r_y == Y_LAST);
  assign w_wall_lo = (r_dy == NEG) && (r_y == '0);
  assign w_edge_l  = (r_dx == NEG) && (r_x == X_ONE);
  assign w_edge_r  = (r_dx == POS) && (r_x == X_PRE);
  always_comb begin
    w_state   = r_state;
    w_x       = r_x;
    w_y       = r_y;
    w_dx      = r_dx;
    w_dy      = r_dy;
    w_cnt     = r_cnt;
    w_score_l = 1'b0;
    w_score_r = 1'b0;
    case (r_state)
      IDLE: begin
        w_state = start ? SERVE : IDLE;
        w_cnt   = '0;
      end
      SERVE: if (w_step) begin
        w_state = (r_cnt == CNT_END) ? PLAY : SERVE;
        w_cnt   = (r_cnt == CNT_END) ? '0 : r_cnt + 1'b1;
      end
      PLAY: if (w_step) begin
        w_y  = w_wall_hi ? Y_PRE : w_wall_lo ? Y_ONE : (r_dy == POS) ? r_y + 1'b1 : r_y - 1'b1;
        w_dy = w_wall_hi ? NEG : w_wall_lo ? POS : r_dy;
        w_x  = (r_dx == POS) ? r_x + 1'b1 : r_x - 1'b1;
        if (w_edge_l) begin
          w_dx      = w_hit_l ? POS : r_dx;
          w_x       = w_hit_l ? X_TWO : '0;
          w_state   = w_hit_l ? PLAY : POINT;
          w_score_r = ~w_hit_l;
        end else if (w_edge_r) begin
          w_dx      = w_hit_r ? NEG : r_dx;
          w_x       = w_hit_r ? X_REB : X_LAST;
          w_state   = w_hit_r ? PLAY : POINT;
          w_score_l = ~w_hit_r;
        end
      end
      POINT: begin
        // serve toward whoever conceded: ball parked at column 0 means the left player missed
        w_state = SERVE;
        w_x     = X_C;
        w_y     = Y_C;
        w_dy    = POS;
        w_dx    = (r_x == '0) ? NEG : POS;
        w_cnt   = '0;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_x       <= X_C;
      r_y       <= Y_C;
      r_dx      <= POS;
      r_dy      <= POS;
      r_cnt     <= '0;
      r_playing <= 1'b0;
      r_score_l <= 1'b0;
      r_score_r <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_x       <= w_x;
      r_y       <= w_y;
      r_dx      <= w_dx;
      r_dy      <= w_dy;
      r_cnt     <= w_cnt;
      r_playing <= (w_state == PLAY);
      r_score_l <= w_score_l;
      r_score_r <= w_score_r;
    end
  end
  assign ball_x  = r_x;
  assign ball_y  = r_y;
  assign playing = r_playing;
  assign score_l = r_score_l;
  assign score_r = r_score_r;
endmodule
